// File: rtl/serpent_core_arb.sv
// serpent_core_arb: round-robin two-requester front end for a Serpent cipher core with result timeout
// Ports: i_clk/i_rst clock and sync reset; i_reqN/i_dataN requests and blocks; o_gntN grant pulses;
// o_validN/o_data shared result; o_err/o_err_id timeout abort; i_subkey_valid key ready;
// o_core_start/o_core_data core launch; i_core_valid/i_core_data core result.
module serpent_core_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [127:0] i_data0,
  input  logic [127:0] i_data1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_valid0,
  output logic         o_valid1,
  output logic [127:0] o_data,
  output logic         o_err,
  output logic         o_err_id,
  input  logic         i_subkey_valid,
  output logic         o_core_start,
  output logic [127:0] o_core_data,
  input  logic         i_core_valid,
  input  logic [127:0] i_core_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_last;
  logic       w_pick;
  // r_last is both the last-served pointer and the owner of the job in flight
  assign w_pick = (i_req0 & i_req1) ? ~r_last : i_req1;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last       <= 1'b1;
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_valid0     <= 1'b0;
      o_valid1     <= 1'b0;
      o_data       <= '0;
      o_err        <= 1'b0;
      o_err_id     <= 1'b0;
      o_core_start <= 1'b0;
      o_core_data  <= '0;
    end else begin
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_valid0     <= 1'b0;
      o_valid1     <= 1'b0;
      o_err        <= 1'b0;
      o_core_start <= 1'b0;
      case (r_state)
        IDLE: if (i_subkey_valid && (i_req0 || i_req1)) begin
          o_gnt0       <= ~w_pick;
          o_gnt1       <= w_pick;
          o_core_start <= 1'b1;
          o_core_data  <= w_pick ? i_data1 : i_data0;
          r_last       <= w_pick;
          r_cnt        <= '0;
          r_state      <= WAIT;
        end
        WAIT: if (i_core_valid) begin
          o_data   <= i_core_data;
          o_valid0 <= ~r_last;
          o_valid1 <= r_last;
          r_state  <= RESP;
        end else if (r_cnt == LAST) begin
          o_err    <= 1'b1;
          o_err_id <= r_last;
          r_state  <= IDLE;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serpent_core_arb.sv
// tb_serpent_core_arb: directed self-checking bench for serpent_core_arb (TIMEOUT 64 and 8 instances)
module tb_serpent_core_arb;
  logic clk = 1'b0;
  logic rst, req0, req1, subkey, cv;
  logic [127:0] data0, data1, cdata;
  logic a_gnt0, a_gnt1, a_valid0, a_valid1, a_err, a_err_id, a_start;
  logic [127:0] a_data, a_cdata;
  logic b_gnt0, b_gnt1, b_valid0, b_valid1, b_err, b_err_id, b_start;
  logic [127:0] b_data, b_cdata;
  int checks = 0, failures = 0;
  int ga0, ga1, sa, va0, va1, overlap;
  localparam logic [127:0] D0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D1 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] A5 = {16{8'hA5}};
  logic [127:0] exp_data;

  always #5 clk = ~clk;

  serpent_core_arb #(.TIMEOUT(64)) u_a (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_data0(data0), .i_data1(data1),
    .o_gnt0(a_gnt0), .o_gnt1(a_gnt1), .o_valid0(a_valid0), .o_valid1(a_valid1), .o_data(a_data),
    .o_err(a_err), .o_err_id(a_err_id), .i_subkey_valid(subkey), .o_core_start(a_start),
    .o_core_data(a_cdata), .i_core_valid(cv), .i_core_data(cdata));

  serpent_core_arb #(.TIMEOUT(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_data0(data0), .i_data1(data1),
    .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_valid0(b_valid0), .o_valid1(b_valid1), .o_data(b_data),
    .o_err(b_err), .o_err_id(b_err_id), .i_subkey_valid(subkey), .o_core_start(b_start),
    .o_core_data(b_cdata), .i_core_valid(cv), .i_core_data(cdata));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ga0 += int'(a_gnt0); ga1 += int'(a_gnt1); sa += int'(a_start);
    va0 += int'(a_valid0); va1 += int'(a_valid1);
    overlap += int'((a_gnt0 & a_gnt1) | (a_valid0 & a_valid1) | (b_gnt0 & b_gnt1) | (b_valid0 & b_valid1));
  endtask

  initial begin
    overlap = 0; ga0 = 0; ga1 = 0; sa = 0; va0 = 0; va1 = 0;
    rst = 1; req0 = 0; req1 = 0; subkey = 0; cv = 0;
    data0 = D0; data1 = D1; cdata = '0;
    tick(); tick();
    rst = 0;
    chk("rst_gnt", {a_gnt0, a_gnt1, b_gnt0, b_gnt1}, 4'b0);
    chk("rst_valid_err", {a_valid0, a_valid1, a_err, a_err_id, a_start}, 5'b0);
    chk("rst_data", a_data, '0);
    chk("rst_cdata", a_cdata, '0);
    ga0 = 0; ga1 = 0; sa = 0; va0 = 0; va1 = 0;
    // single request, core answers 33 cycles after start
    subkey = 1; req0 = 1;
    tick();
    chk("single_gnt0", a_gnt0, 1'b1);
    chk("single_start", a_start, 1'b1);
    chk("single_cdata", a_cdata, D0);
    req0 = 0;
    for (int i = 0; i < 32; i++) tick();
    chk("single_no_early_valid", va0, 0);
    cv = 1; cdata = A5;
    tick();
    cv = 0;
    chk("single_valid0", a_valid0, 1'b1);
    chk("single_data", a_data, A5);
    tick();
    chk("single_valid_pulse", a_valid0, 1'b0);
    chk("single_counts", {ga0[7:0], ga1[7:0], sa[7:0], va0[7:0], va1[7:0]}, {8'd1, 8'd0, 8'd1, 8'd1, 8'd0});
    chk("single_cdata_held", a_cdata, D0);
    // contention on the TIMEOUT=8 instance after a fresh reset
    rst = 1; tick(); rst = 0;
    req0 = 1; req1 = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("cont%0d_gnt", j), {b_gnt0, b_gnt1}, (j % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_cdata", j), b_cdata, (j % 2 == 0) ? D0 : D1);
      cv = 1; cdata = {120'h0, 8'(j + 1)};
      tick();
      cv = 0;
      chk($sformatf("cont%0d_valid", j), {b_valid0, b_valid1}, (j % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_data", j), b_data, {120'h0, 8'(j + 1)});
      tick();
      chk($sformatf("cont%0d_resp_no_gnt", j), {b_gnt0, b_gnt1}, 2'b00);
    end
    exp_data = {120'h0, 8'd4};
    // key gating: requests held, no key for 10 cycles
    subkey = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_no_gnt", {b_gnt0, b_gnt1, b_start}, 3'b000);
    end
    subkey = 1;
    tick();
    chk("gate_gnt_after_key", {b_gnt0, b_gnt1, b_start}, 3'b101);
    req0 = 0; req1 = 0;
    // core never responds: error 8 cycles after start
    for (int i = 0; i < 7; i++) tick();
    chk("to_no_early_err", b_err, 1'b0);
    tick();
    chk("to_err", b_err, 1'b1);
    chk("to_err_id", b_err_id, 1'b0);
    chk("to_no_valid", {b_valid0, b_valid1}, 2'b00);
    chk("to_data_kept", b_data, exp_data);
    req1 = 1;
    tick();
    chk("to_err_pulse", b_err, 1'b0);
    chk("to_idle_regrant", {b_gnt0, b_gnt1}, 2'b01);
    req1 = 0;
    // result at exactly counter = TIMEOUT-1 wins
    for (int i = 0; i < 7; i++) tick();
    cv = 1; cdata = A5;
    tick();
    cv = 0;
    chk("edge_valid1", {b_valid0, b_valid1}, 2'b01);
    chk("edge_no_err", b_err, 1'b0);
    chk("edge_data", b_data, A5);
    tick();
    chk("edge_no_late_err", b_err, 1'b0);
    // reset in the middle of a job, then a stale core result
    req0 = 1;
    tick();
    chk("mid_gnt0", b_gnt0, 1'b1);
    req0 = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_ctl", {b_gnt0, b_gnt1, b_valid0, b_valid1, b_err, b_err_id, b_start}, 7'b0);
    chk("mid_rst_data", b_data, '0);
    chk("mid_rst_cdata", b_cdata, '0);
    cv = 1; cdata = D1;
    tick();
    cv = 0;
    chk("mid_late_valid", {b_valid0, b_valid1}, 2'b00);
    chk("mid_late_data", b_data, '0);
    req0 = 1; req1 = 1;
    tick();
    chk("mid_tie_gnt0", {b_gnt0, b_gnt1}, 2'b10);
    chk("mid_tie_cdata", b_cdata, D0);
    req0 = 0; req1 = 0;
    tick();
    chk("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
